mem_arbiter: RTL and testbench

Two-port arbiter that shares the single `memory0` instance between two bus masters: port 0 is the CPU side and port 1 is a DMA/loader side. It sits between the masters and the memory's `en`/`rw`/`m_size`/`abus`/`dbus_in`/`dbus_out` pins. It serialises accesses through a small state machine with a req/ack handshake, and it rejects out-of-range addresses without touching memory.

---
 rtl/mem_arbiter_if.sv | 15 +
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one master's request port into mem_arbiter
// Master drives req/rw/size/addr/wdata and holds them until ack;
// slave (the arbiter) returns registered rdata and a one-cycle ack with err.
interface mem_arbiter_if;
    logic        req;
    logic        rw;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    modport master (output req, rw, size, addr, wdata, input rdata, ack, err);
    modport slave  (input req, rw, size, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two masters onto a single memory0 instance
// Ports: clock, reset (synchronous, active-low);
//   p0 (CPU) and p1 (DMA/loader) request ports, mem_arbiter_if.slave;
//   m_en/m_rw/m_size/m_addr/m_wdata drive memory en/rw/m_size/abus/dbus_in;
//   m_rdata comes from memory dbus_out;
//   busy is high outside IDLE; grant_id is the current or last winner.
// Build option: MEM_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration,
//   otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int MEMSIZE     = 'h10000,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave p0,
    mem_arbiter_if.slave p1,
    output logic         m_en,
    output logic         m_rw,
    output logic [1:0]   m_size,
    output logic [31:0]  m_addr,
    output logic [31:0]  m_wdata,
    input  logic [31:0]  m_rdata,
    output logic         busy,
    output logic         grant_id
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [31:0] LAST_ADDR = 32'(MEMSIZE - 4);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gid_q, gid_d, err_q, err_d, rw_q, rw_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        win, sel_rw, oor;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // On a tie the grant goes to the port that did not win last time.
    assign win = (p0.req && p1.req) ? !gid_q : p1.req;
`else
    assign win = !p0.req;
`endif
    assign sel_rw    = win ? p1.rw    : p0.rw;
    assign sel_size  = win ? p1.size  : p0.size;
    assign sel_addr  = win ? p1.addr  : p0.addr;
    assign sel_wdata = win ? p1.wdata : p0.wdata;
    assign oor       = sel_addr > LAST_ADDR;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gid_d    = gid_q;
        err_d    = err_q;
        rw_d     = rw_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: if (p0.req || p1.req) begin
                gid_d   = win;
                rw_d    = sel_rw;
                size_d  = sel_size;
                addr_d  = sel_addr;
                wdata_d = sel_wdata;
                err_d   = oor;
                cnt_d   = 4'(WAIT_CYCLES - 1);
                state_d = oor ? DONE : ACCESS;
                // A rejected read returns zero; a rejected write leaves rdata alone.
                if (oor && sel_rw) begin
                    rdata0_d = win ? rdata0_q : '0;
                    rdata1_d = win ? '0 : rdata1_q;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (rw_q) begin
                        rdata0_d = gid_q ? rdata0_q : m_rdata;
                        rdata1_d = gid_q ? m_rdata : rdata1_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gid_q    <= 1'b1;
            err_q    <= 1'b0;
            rw_q     <= 1'b1;
            size_q   <= 2'b11;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gid_q    <= gid_d;
            err_q    <= err_d;
            rw_q     <= rw_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end
    assign m_en     = state_q == ACCESS;
    assign m_rw     = rw_q;
    assign m_size   = size_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign busy     = state_q != IDLE;
    assign grant_id = gid_q;
    assign p0.ack   = (state_q == DONE) && !gid_q;
    assign p1.ack   = (state_q == DONE) && gid_q;
    assign p0.err   = p0.ack && err_q;
    assign p1.err   = p1.ack && err_q;
    assign p0.rdata = rdata0_q;
    assign p1.rdata = rdata1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a big-endian byte memory model
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic reset4 = 1'b0;
    always #5 clock = ~clock;

    mem_arbiter_if p0_if ();
    mem_arbiter_if p1_if ();
    mem_arbiter_if q0_if ();
    mem_arbiter_if q1_if ();

    logic        m_en, m_rw, busy, grant_id;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_en4, m_rw4, busy4, gid4;
    logic [1:0]  m_size4;
    logic [31:0] m_addr4, m_wdata4, m_rdata4;
    assign m_rdata4 = 32'h0;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [0:65535];

    mem_arbiter #(.MEMSIZE('h10000), .WAIT_CYCLES(1)) dut (
        .clock(clock), .reset(reset), .p0(p0_if), .p1(p1_if),
        .m_en(m_en), .m_rw(m_rw), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy), .grant_id(grant_id)
    );

    mem_arbiter #(.MEMSIZE('h10000), .WAIT_CYCLES(4)) dut4 (
        .clock(clock), .reset(reset4), .p0(q0_if), .p1(q1_if),
        .m_en(m_en4), .m_rw(m_rw4), .m_size(m_size4), .m_addr(m_addr4),
        .m_wdata(m_wdata4), .m_rdata(m_rdata4), .busy(busy4), .grant_id(gid4)
    );

    // Byte at addr is the most significant byte of the access; data is right-aligned.
    always @(posedge clock)
        if (m_en && !m_rw)
            for (int i = 0; i < 4; i++)
                if (i <= int'(m_size))
                    mem[16'(m_addr + 32'(i))] <= m_wdata[8*(int'(m_size)-i) +: 8];

    always_comb begin
        m_rdata = '0;
        for (int i = 0; i < 4; i++)
            if (i <= int'(m_size))
                m_rdata = {m_rdata[23:0], mem[16'(m_addr + 32'(i))]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_access(input bit port, input bit rw, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rd, output logic er,
                             output int lat, output logic en_seen);
        logic ack;
        @(negedge clock);
        if (port) begin
            p1_if.rw = rw; p1_if.size = size; p1_if.addr = addr; p1_if.wdata = wdata; p1_if.req = 1'b1;
        end else begin
            p0_if.rw = rw; p0_if.size = size; p0_if.addr = addr; p0_if.wdata = wdata; p0_if.req = 1'b1;
        end
        lat = 0;
        en_seen = 1'b0;
        ack = 1'b0;
        while (!ack && lat < 20) begin
            @(negedge clock);
            lat++;
            en_seen |= m_en;
            ack = port ? p1_if.ack : p0_if.ack;
        end
        rd = port ? p1_if.rdata : p0_if.rdata;
        er = port ? p1_if.err : p0_if.err;
        p0_if.req = 1'b0;
        p1_if.req = 1'b0;
    endtask

    task automatic pair(output int first, output int second, output int n);
        @(negedge clock);
        p0_if.rw = 1'b1; p0_if.size = 2'b11; p0_if.addr = 32'h0; p0_if.req = 1'b1;
        p1_if.rw = 1'b1; p1_if.size = 2'b11; p1_if.addr = 32'h4; p1_if.req = 1'b1;
        n = 0;
        first = -1;
        second = -1;
        for (int t = 0; t < 30 && (p0_if.req || p1_if.req); t++) begin
            @(negedge clock);
            if (p0_if.ack) begin
                if (n == 0) first = 0; else second = 0;
                n++;
                p0_if.req = 1'b0;
            end
            if (p1_if.ack) begin
                if (n == 0) first = 1; else second = 1;
                n++;
                p1_if.req = 1'b0;
            end
        end
        p0_if.req = 1'b0;
        p1_if.req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic er, en, ack_seen;
        int lat, f, s, n;
        p0_if.req = 0; p0_if.rw = 1; p0_if.size = 3; p0_if.addr = 0; p0_if.wdata = 0;
        p1_if.req = 0; p1_if.rw = 1; p1_if.size = 3; p1_if.addr = 0; p1_if.wdata = 0;
        q0_if.req = 0; q0_if.rw = 1; q0_if.size = 3; q0_if.addr = 0; q0_if.wdata = 0;
        q1_if.req = 0; q1_if.rw = 1; q1_if.size = 3; q1_if.addr = 0; q1_if.wdata = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        reset4 = 1'b1;
        @(negedge clock);

        check("rst_p0_ack", 32'(p0_if.ack), 0);
        check("rst_p0_err", 32'(p0_if.err), 0);
        check("rst_p0_rdata", p0_if.rdata, 0);
        check("rst_p1_ack", 32'(p1_if.ack), 0);
        check("rst_p1_err", 32'(p1_if.err), 0);
        check("rst_p1_rdata", p1_if.rdata, 0);
        check("rst_m_en", 32'(m_en), 0);
        check("rst_m_rw", 32'(m_rw), 1);
        check("rst_m_size", 32'(m_size), 3);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_id", 32'(grant_id), 1);
        check("rst4_m_en", 32'(m_en4), 0);
        check("rst4_grant_id", 32'(gid4), 1);

        do_access(0, 0, 2'b11, 32'h100, 32'hDEADBEEF, rd, er, lat, en);
        check("wr0_lat", 32'(lat), 2);
        check("wr0_err", 32'(er), 0);
        check("wr0_m_en", 32'(en), 1);
        check("wr0_m_addr", m_addr, 32'h100);
        check("wr0_grant", 32'(grant_id), 0);

        do_access(0, 1, 2'b11, 32'h100, 32'h0, rd, er, lat, en);
        check("rd0_lat", 32'(lat), 2);
        check("rd0_err", 32'(er), 0);
        check("rd0_rdata", rd, 32'hDEADBEEF);

        do_access(1, 1, 2'b11, 32'h100, 32'h0, rd, er, lat, en);
        check("rd1_rdata", rd, 32'hDEADBEEF);
        check("rd1_grant", 32'(grant_id), 1);

        do_access(1, 0, 2'b11, 32'hFFFD, 32'h12345678, rd, er, lat, en);
        check("oorw_lat", 32'(lat), 1);
        check("oorw_err", 32'(er), 1);
        check("oorw_m_en", 32'(en), 0);
        check("oorw_rdata_hold", rd, 32'hDEADBEEF);

        do_access(1, 1, 2'b11, 32'hFFFC, 32'h0, rd, er, lat, en);
        check("edge_lat", 32'(lat), 2);
        check("edge_err", 32'(er), 0);

        do_access(1, 1, 2'b11, 32'h10000, 32'h0, rd, er, lat, en);
        check("oorr_lat", 32'(lat), 1);
        check("oorr_err", 32'(er), 1);
        check("oorr_m_en", 32'(en), 0);
        check("oorr_rdata", rd, 0);
        check("oorr_p0_hold", p0_if.rdata, 32'hDEADBEEF);

        pair(f, s, n);
        check("pair1_n", 32'(n), 2);
        check("pair1_first", 32'(f), 0);
        check("pair1_second", 32'(s), 1);

        do_access(0, 0, 2'b11, 32'h0, 32'hCAFEF00D, rd, er, lat, en);
        pair(f, s, n);
        check("pair2_n", 32'(n), 2);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        check("pair2_first", 32'(f), 1);
        check("pair2_second", 32'(s), 0);
`else
        check("pair2_first", 32'(f), 0);
        check("pair2_second", 32'(s), 1);
`endif

        do_access(1, 0, 2'b11, 32'h200, 32'h11223344, rd, er, lat, en);
        do_access(1, 0, 2'b00, 32'h200, 32'h00000041, rd, er, lat, en);
        check("byte_err", 32'(er), 0);
        do_access(1, 1, 2'b11, 32'h200, 32'h0, rd, er, lat, en);
        check("byte_rdata", rd, 32'h41223344);

        @(negedge clock);
        q0_if.rw = 0; q0_if.size = 3; q0_if.addr = 32'h20; q0_if.wdata = 32'h55; q0_if.req = 1;
        lat = 0;
        ack_seen = 0;
        while (!ack_seen && lat < 20) begin
            @(negedge clock);
            lat++;
            ack_seen = q0_if.ack;
        end
        q0_if.req = 0;
        check("w4_lat", 32'(lat), 5);

        @(negedge clock);
        q0_if.rw = 1; q0_if.addr = 32'h10; q0_if.req = 1;
        @(negedge clock);
        @(negedge clock);
        check("mid_m_en_before", 32'(m_en4), 1);
        check("mid_busy_before", 32'(busy4), 1);
        reset4 = 1'b0;
        q0_if.req = 0;
        @(negedge clock);
        check("mid_m_en_after", 32'(m_en4), 0);
        check("mid_busy_after", 32'(busy4), 0);
        reset4 = 1'b1;
        ack_seen = q0_if.ack;
        repeat (6) begin
            @(negedge clock);
            ack_seen |= q0_if.ack;
        end
        check("mid_no_ack", 32'(ack_seen), 0);
        check("mid_idle", 32'(busy4), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
